led_rotation_sequencer: RTL and testbench

- Parametrised successor to the single-width rotation counter.
- Sequences a WS2812B pattern offset (0..NUM_LEDS-1) across frames, handshaking with the frame generator/sender.
- Requests a frame, waits for frame completion, and holds each offset for a programmable number of frames.
- Then advances the offset forward, reverse, or ping-pong by a programmable step, with wrap/bounce flags. Sits between control logic and the pattern generator on the 100 MHz Basys3 clock.

---
 rtl/led_seq_pkg.sv | 22 ++
 rtl/rotation_step_calc.sv | 83 ++++++++
 rtl/led_rotation_sequencer.sv | 140 ++++++++++++++
 tb/tb_led_rotation_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared encodings for the LED rotation sequencer.
// Modes, FSM states and direction constants.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'd0,
    MODE_FWD  = 2'd1,
    MODE_REV  = 2'd2,
    MODE_PING = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_ADVANCE   = 2'd3
  } state_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/rotation_step_calc.sv
// Combinational next-offset/next-dir/wrap computation.
// All arithmetic is widened by one bit before comparing.
module rotation_step_calc
  import led_seq_pkg::*;
#(
  parameter int NUM_LEDS = 8,
  parameter int IDX_W    = $clog2(NUM_LEDS)
) (
  input  logic [IDX_W-1:0] offset,
  input  logic             dir,
  input  mode_e            mode,
  input  logic [IDX_W-1:0] step,
  output logic [IDX_W-1:0] next_offset,
  output logic             next_dir,
  output logic             wrap,
  output logic             moves
);

  localparam logic [IDX_W:0] LEDS = (IDX_W+1)'(NUM_LEDS);
  localparam logic [IDX_W:0] LAST = LEDS - 1'b1;

  logic [IDX_W:0] off_ext;
  logic [IDX_W:0] s_ext;
  logic [IDX_W:0] sum;

  assign off_ext = {1'b0, offset};
  assign s_ext   = {1'b0, step};
  assign sum     = off_ext + s_ext;

  // Select the step/wrap/bounce result for the current mode.
  always_comb begin
    next_offset = offset;
    next_dir    = dir;
    wrap        = 1'b0;
    moves       = 1'b0;
    unique case (mode)
      MODE_HOLD: begin
        moves = 1'b0;
      end
      MODE_FWD: begin
        moves    = 1'b1;
        next_dir = DIR_UP;
        if (sum >= LEDS) begin
          next_offset = IDX_W'(sum - LEDS);
          wrap        = 1'b1;
        end else begin
          next_offset = IDX_W'(sum);
        end
      end
      MODE_REV: begin
        moves    = 1'b1;
        next_dir = DIR_DOWN;
        if (off_ext < s_ext) begin
          next_offset = IDX_W'(off_ext + LEDS - s_ext);
          wrap        = 1'b1;
        end else begin
          next_offset = IDX_W'(off_ext - s_ext);
        end
      end
      MODE_PING: begin
        moves = 1'b1;
        if (dir == DIR_UP) begin
          if (sum > LAST) begin
            next_offset = IDX_W'(LAST);
            next_dir    = DIR_DOWN;
            wrap        = 1'b1;
          end else begin
            next_offset = IDX_W'(sum);
          end
        end else begin
          if (off_ext < s_ext) begin
            next_offset = '0;
            next_dir    = DIR_UP;
            wrap        = 1'b1;
          end else begin
            next_offset = IDX_W'(off_ext - s_ext);
          end
        end
      end
    endcase
  end

endmodule

// File: rtl/led_rotation_sequencer.sv
// Frame-synchronous rotation offset sequencer.
// Requests frames, counts holds and advances the offset.
module led_rotation_sequencer
  import led_seq_pkg::*;
#(
  parameter int NUM_LEDS = 8,
  parameter int IDX_W    = $clog2(NUM_LEDS),
  parameter int HOLD_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [IDX_W-1:0]  step_by,
  input  logic [HOLD_W-1:0] hold_frames,
  input  logic              frame_done,
  output logic              frame_start,
  output logic [IDX_W-1:0]  offset,
  output logic              dir,
  output logic              step_pulse,
  output logic              wrap_pulse,
  output logic              busy
);

  localparam logic [IDX_W:0] LAST = (IDX_W+1)'(NUM_LEDS - 1);

  state_e            state;
  logic [HOLD_W-1:0] frame_cnt;

  logic [IDX_W:0]    step_ext;
  logic [IDX_W-1:0]  step_s;
  logic [HOLD_W:0]   hold_eff;
  logic [HOLD_W:0]   cnt_next;
  logic              hold_due;

  logic [IDX_W-1:0]  calc_offset;
  logic              calc_dir;
  logic              calc_wrap;
  logic              calc_moves;

  // Clamp step to ring length and decide if the hold is used up.
  always_comb begin
    step_ext = {1'b0, step_by};
    step_s   = step_by;
    if (step_ext > LAST) begin
      step_s = IDX_W'(LAST);
    end
    hold_eff = {1'b0, hold_frames};
    if (hold_frames == '0) begin
      hold_eff = (HOLD_W+1)'(1);
    end
    cnt_next = {1'b0, frame_cnt} + 1'b1;
    hold_due = (cnt_next >= hold_eff);
  end

  rotation_step_calc #(
    .NUM_LEDS (NUM_LEDS),
    .IDX_W    (IDX_W)
  ) u_calc (
    .offset      (offset),
    .dir         (dir),
    .mode        (mode_e'(mode)),
    .step        (step_s),
    .next_offset (calc_offset),
    .next_dir    (calc_dir),
    .wrap        (calc_wrap),
    .moves       (calc_moves)
  );

  // FSM, hold counter and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      frame_cnt   <= '0;
      offset      <= '0;
      dir         <= DIR_UP;
      frame_start <= 1'b0;
      step_pulse  <= 1'b0;
      wrap_pulse  <= 1'b0;
      busy        <= 1'b0;
    end else if (clear) begin
      state       <= ST_IDLE;
      frame_cnt   <= '0;
      offset      <= '0;
      dir         <= DIR_UP;
      frame_start <= 1'b0;
      step_pulse  <= 1'b0;
      wrap_pulse  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      step_pulse  <= 1'b0;
      wrap_pulse  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (enable) begin
            state       <= ST_START;
            frame_start <= 1'b1;
            busy        <= 1'b1;
          end
        end
        ST_START: begin
          state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (frame_done) begin
            if (hold_due) begin
              frame_cnt <= '0;
              state     <= ST_ADVANCE;
            end else begin
              frame_cnt <= HOLD_W'(cnt_next);
              if (enable) begin
                state       <= ST_START;
                frame_start <= 1'b1;
              end else begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end
            end
          end
        end
        ST_ADVANCE: begin
          offset     <= calc_offset;
          dir        <= calc_dir;
          step_pulse <= calc_moves;
          wrap_pulse <= calc_wrap;
          if (enable) begin
            state       <= ST_START;
            frame_start <= 1'b1;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_rotation_sequencer.sv
// Directed bench for led_rotation_sequencer.
// Frame table plus reset/clear/handshake sequences.
module tb_led_rotation_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic       enable;
  logic [1:0] mode;
  logic [2:0] step_by;
  logic [7:0] hold_frames;
  logic       frame_done;
  logic       frame_start;
  logic [2:0] offset;
  logic       dir;
  logic       step_pulse;
  logic       wrap_pulse;
  logic       busy;

  logic       clear2;
  logic       enable2;
  logic [1:0] mode2;
  logic [2:0] step_by2;
  logic [7:0] hold2;
  logic       done2;
  logic       fs2;
  logic [2:0] offset2;
  logic       dir2;
  logic       step2;
  logic       wrap2;
  logic       busy2;

  int total = 0;
  int bad = 0;
  int fs_count = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_start) fs_count++;
  end

  led_rotation_sequencer #(.NUM_LEDS(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .enable      (enable),
    .mode        (mode),
    .step_by     (step_by),
    .hold_frames (hold_frames),
    .frame_done  (frame_done),
    .frame_start (frame_start),
    .offset      (offset),
    .dir         (dir),
    .step_pulse  (step_pulse),
    .wrap_pulse  (wrap_pulse),
    .busy        (busy)
  );

  led_rotation_sequencer #(.NUM_LEDS(6)) dut6 (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear2),
    .enable      (enable2),
    .mode        (mode2),
    .step_by     (step_by2),
    .hold_frames (hold2),
    .frame_done  (done2),
    .frame_start (fs2),
    .offset      (offset2),
    .dir         (dir2),
    .step_pulse  (step2),
    .wrap_pulse  (wrap2),
    .busy        (busy2)
  );

  typedef struct {
    bit         fresh;
    logic [1:0] mode;
    logic [2:0] step;
    logic [7:0] hold;
    bit         adv;
    logic [2:0] off;
    bit         dir;
    bit         wrap;
    bit         stp;
  } row_t;

  row_t rows[26];

  function automatic row_t r(bit fr, int m, int s, int h, bit a,
                             int o, bit d, bit w, bit p);
    row_t x;
    x.fresh = fr;
    x.mode  = 2'(m);
    x.step  = 3'(s);
    x.hold  = 8'(h);
    x.adv   = a;
    x.off   = 3'(o);
    x.dir   = d;
    x.wrap  = w;
    x.stp   = p;
    return x;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".offset"}, int'(offset), 0);
    check({tag, ".dir"}, int'(dir), 0);
    check({tag, ".busy"}, int'(busy), 0);
    check({tag, ".step"}, int'(step_pulse), 0);
    check({tag, ".wrap"}, int'(wrap_pulse), 0);
    check({tag, ".fs"}, int'(frame_start), 0);
  endtask

  task automatic restart();
    clear = 1'b1;
    enable = 1'b1;
    tick();
    check_idle("clr");
    clear = 1'b0;
    tick();
  endtask

  task automatic run_row(input int i);
    string t;
    t = $sformatf("row%0d", i);
    mode = rows[i].mode;
    step_by = rows[i].step;
    hold_frames = rows[i].hold;
    check({t, ".fs_start"}, int'(frame_start), 1);
    tick();
    check({t, ".fs_wait"}, int'(frame_start), 0);
    check({t, ".busy"}, int'(busy), 1);
    tick();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    if (!rows[i].adv) begin
      check({t, ".fs_next"}, int'(frame_start), 1);
      check({t, ".step"}, int'(step_pulse), 0);
      check({t, ".offset"}, int'(offset), int'(rows[i].off));
    end else begin
      check({t, ".step_early"}, int'(step_pulse), 0);
      check({t, ".fs_adv"}, int'(frame_start), 0);
      tick();
      check({t, ".offset"}, int'(offset), int'(rows[i].off));
      check({t, ".dir"}, int'(dir), int'(rows[i].dir));
      check({t, ".wrap"}, int'(wrap_pulse), int'(rows[i].wrap));
      check({t, ".step"}, int'(step_pulse), int'(rows[i].stp));
      check({t, ".fs_after"}, int'(frame_start), 1);
    end
  endtask

  task automatic hand_reset();
    tick();
    #2;
    reset = 1'b0;
    #1;
    check_idle("areset");
    reset = 1'b1;
  endtask

  task automatic hand_clear();
    tick();
    clear = 1'b1;
    frame_done = 1'b1;
    tick();
    check_idle("clr_run");
    clear = 1'b0;
    frame_done = 1'b0;
    enable = 1'b0;
    tick();
    check("clr_run.idle_busy", int'(busy), 0);
    check("clr_run.idle_fs", int'(frame_start), 0);
  endtask

  task automatic hand_ignore();
    enable = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    mode = 2'd1;
    step_by = 3'd1;
    hold_frames = 8'd2;
    frame_done = 1'b1;
    tick();
    check("ign.idle_busy", int'(busy), 0);
    check("ign.idle_fs", int'(frame_start), 0);
    frame_done = 1'b0;
    enable = 1'b1;
    tick();
    check("ign.start_fs", int'(frame_start), 1);
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    tick();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    check("ign.first_fs", int'(frame_start), 1);
    check("ign.first_step", int'(step_pulse), 0);
    tick();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    tick();
    check("ign.second_step", int'(step_pulse), 1);
    check("ign.second_off", int'(offset), 1);
  endtask

  task automatic hand_enable_drop();
    int snap;
    mode = 2'd1;
    step_by = 3'd1;
    hold_frames = 8'd1;
    tick();
    enable = 1'b0;
    tick();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    check("drop.adv_busy", int'(busy), 1);
    tick();
    check("drop.offset", int'(offset), 3);
    check("drop.step", int'(step_pulse), 1);
    check("drop.fs", int'(frame_start), 0);
    check("drop.busy", int'(busy), 0);
    snap = fs_count;
    repeat (4) tick();
    check("drop.no_more_fs", fs_count, snap);
    check("drop.busy_stays", int'(busy), 0);
  endtask

  task automatic hand_clamp();
    int exp_off[2];
    int exp_wrap[2];
    exp_off[0] = 5;
    exp_off[1] = 4;
    exp_wrap[0] = 0;
    exp_wrap[1] = 1;
    enable2 = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("clamp%0d.fs", k), int'(fs2), 1);
      tick();
      done2 = 1'b1;
      tick();
      done2 = 1'b0;
      tick();
      check($sformatf("clamp%0d.off", k), int'(offset2), exp_off[k]);
      check($sformatf("clamp%0d.wrap", k), int'(wrap2), exp_wrap[k]);
      check($sformatf("clamp%0d.step", k), int'(step2), 1);
    end
  endtask

  initial begin
    rows[0]  = r(1, 1, 3, 1, 1, 3, 0, 0, 1);
    rows[1]  = r(0, 1, 3, 1, 1, 6, 0, 0, 1);
    rows[2]  = r(0, 1, 3, 1, 1, 1, 0, 1, 1);
    rows[3]  = r(0, 1, 3, 1, 1, 4, 0, 0, 1);
    rows[4]  = r(1, 2, 2, 1, 1, 6, 1, 1, 1);
    rows[5]  = r(0, 2, 2, 1, 1, 4, 1, 0, 1);
    rows[6]  = r(0, 2, 2, 1, 1, 2, 1, 0, 1);
    rows[7]  = r(1, 3, 3, 1, 1, 3, 0, 0, 1);
    rows[8]  = r(0, 3, 3, 1, 1, 6, 0, 0, 1);
    rows[9]  = r(0, 3, 3, 1, 1, 7, 1, 1, 1);
    rows[10] = r(0, 3, 3, 1, 1, 4, 1, 0, 1);
    rows[11] = r(0, 3, 3, 1, 1, 1, 1, 0, 1);
    rows[12] = r(0, 3, 3, 1, 1, 0, 0, 1, 1);
    rows[13] = r(1, 1, 1, 3, 0, 0, 0, 0, 0);
    rows[14] = r(0, 1, 1, 3, 0, 0, 0, 0, 0);
    rows[15] = r(0, 1, 1, 3, 1, 1, 0, 0, 1);
    rows[16] = r(0, 1, 1, 3, 0, 1, 0, 0, 0);
    rows[17] = r(0, 1, 1, 3, 0, 1, 0, 0, 0);
    rows[18] = r(0, 1, 1, 3, 1, 2, 0, 0, 1);
    rows[19] = r(1, 1, 1, 0, 1, 1, 0, 0, 1);
    rows[20] = r(0, 1, 1, 0, 1, 2, 0, 0, 1);
    rows[21] = r(0, 0, 1, 1, 1, 2, 0, 0, 0);
    rows[22] = r(0, 1, 7, 1, 1, 1, 0, 1, 1);
    rows[23] = r(0, 1, 0, 1, 1, 1, 0, 0, 1);
    rows[24] = r(0, 2, 7, 1, 1, 2, 1, 1, 1);
    rows[25] = r(0, 3, 0, 1, 1, 2, 1, 0, 1);

    reset = 1'b0;
    clear = 1'b0;
    enable = 1'b0;
    mode = 2'd0;
    step_by = 3'd0;
    hold_frames = 8'd1;
    frame_done = 1'b0;
    clear2 = 1'b0;
    enable2 = 1'b0;
    mode2 = 2'd1;
    step_by2 = 3'd7;
    hold2 = 8'd1;
    done2 = 1'b0;
    repeat (2) tick();
    check_idle("reset");
    #2;
    reset = 1'b1;

    for (int i = 0; i < 26; i++) begin
      if (i == 4) hand_reset();
      if (i == 7) hand_clear();
      if (i == 13) hand_ignore();
      if (rows[i].fresh) restart();
      run_row(i);
    end

    hand_enable_drop();
    hand_clamp();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
